// File: rtl/me_block_scheduler.sv
// Frame-level sequencer for the motion-estimator core. Walks the core through
// NUM_BLOCKS macroblock searches. Each result goes out on a valid/ready stream,
// and the block keeps a running frame-minimum distance.
module me_block_scheduler #(
   parameter int unsigned NUM_BLOCKS       = 16,
   parameter int unsigned IDX_W            = 4,
   parameter int unsigned START_LOW_CYCLES = 2,
   parameter int unsigned TIMEOUT_CYCLES   = 5000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              go,
   output logic              me_start,
   input  logic              me_completed,
   input  logic [7:0]        me_best_dist,
   input  logic [3:0]        me_motion_x,
   input  logic [3:0]        me_motion_y,
   output logic [IDX_W-1:0]  block_idx,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [16+IDX_W:0] res_data,
   output logic              busy,
   output logic              done,
   output logic              timeout_err,
   output logic [7:0]        frame_min_dist,
   output logic [IDX_W-1:0]  frame_min_idx,
   output logic              frame_min_vld
);

   // One counter serves both the start-low gap and the run timeout.
   localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > START_LOW_CYCLES) ?
                                     TIMEOUT_CYCLES : START_LOW_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(START_LOW_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLOCKS - 1);

   typedef enum logic [2:0] {
      StIdle,
      StPre,
      StRun,
      StEmit,
      StDone
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             res_err;
   logic [7:0]       res_dist;

   // Fields of the held result, used for the frame-minimum update at handshake.
   assign res_err  = res_data[16+IDX_W];
   assign res_dist = res_data[15:8];

   // Sequencer FSM; every output is registered here.
   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= StIdle;
         cnt            <= '0;
         me_start       <= 1'b0;
         block_idx      <= '0;
         res_valid      <= 1'b0;
         res_data       <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         timeout_err    <= 1'b0;
         frame_min_dist <= 8'hFF;
         frame_min_idx  <= '0;
         frame_min_vld  <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            StIdle: begin
               if (go) begin
                  state          <= StPre;
                  cnt            <= '0;
                  block_idx      <= '0;
                  timeout_err    <= 1'b0;
                  frame_min_dist <= 8'hFF;
                  frame_min_idx  <= '0;
                  frame_min_vld  <= 1'b0;
                  busy           <= 1'b1;
               end
            end
            StPre: begin
               if (cnt == PRE_LAST) begin
                  state    <= StRun;
                  cnt      <= '0;
                  me_start <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            StRun: begin
               // Completed in run cycle 0 is left over from the previous block.
               if (cnt != '0 && me_completed) begin
                  res_data  <= {1'b0, block_idx, me_best_dist, me_motion_x, me_motion_y};
                  res_valid <= 1'b1;
                  state     <= StEmit;
               end else if (cnt == TO_LAST) begin
                  res_data    <= {1'b1, block_idx, 8'hFF, 4'h0, 4'h0};
                  timeout_err <= 1'b1;
                  res_valid   <= 1'b1;
                  state       <= StEmit;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            StEmit: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  me_start  <= 1'b0;
                  cnt       <= '0;
                  // Strict compare so a tie keeps the earlier block.
                  if (!res_err && (!frame_min_vld || res_dist < frame_min_dist)) begin
                     frame_min_dist <= res_dist;
                     frame_min_idx  <= block_idx;
                     frame_min_vld  <= 1'b1;
                  end
                  if (block_idx == LAST_IDX) begin
                     state <= StDone;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     block_idx <= block_idx + 1'b1;
                     state     <= StPre;
                  end
               end
            end
            StDone: begin
               state <= StIdle;
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule
